// File: rtl/std_div_seq.sv
// Unsigned iterative restoring divider with go/done handshake; one quotient bit per cycle.
// Optional macro STD_DIV_SEQ_ZERO_SKIP_EN finishes a divide-by-zero in one cycle.
module std_div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic [CW-1:0]    count_q, count_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_div;

  // Trial is one bit wider than the remainder so the compare never overflows;
  // when it fits, the difference is below the divisor and fits in WIDTH bits.
  always_comb begin
    trial    = {rem_q, dividend_q[WIDTH-1]};
    fits     = (trial >= {1'b0, divisor_q});
    step_rem = fits ? (trial[WIDTH-1:0] - divisor_q) : trial[WIDTH-1:0];
    step_div = {dividend_q[WIDTH-2:0], fits};
  end

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    remo_d     = remo_q;
    count_d    = count_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          dividend_d = left;
          divisor_d  = right;
          rem_d      = '0;
          count_d    = CW'(WIDTH);
          state_d    = S_RUN;
`ifdef STD_DIV_SEQ_ZERO_SKIP_EN
          if (right == '0) begin
            quot_d  = '1;
            remo_d  = left;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_RUN: begin
        dividend_d = step_div;
        rem_d      = step_rem;
        count_d    = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          quot_d  = step_div;
          remo_d  = step_rem;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      remo_q     <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      remo_q     <= remo_d;
      count_q    <= count_d;
      done_q     <= done_d;
    end
  end

`ifdef STD_DIV_SEQ_ZERO_SKIP_EN
  always_ff @(posedge clk) begin
    if (!reset && state_q == S_IDLE && go && right == '0) begin
      $error("std_div_seq: divide by zero");
    end
  end
`endif

  assign out_quotient  = quot_q;
  assign out_remainder = remo_q;
  assign done          = done_q;

endmodule

// File: tb/tb_std_div_seq.sv
// Self-checking bench for std_div_seq: cycle-timeline reference model plus directed literal checks.
// Honours STD_DIV_SEQ_ZERO_SKIP_EN for the expected divide-by-zero latency.
module tb_std_div_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         go = 1'b0;
    logic [W-1:0] left = '0;
    logic [W-1:0] right = '0;
    logic [W-1:0] out_q;
    logic [W-1:0] out_r;
    logic         done;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // Reference model: an operation accepted in cycle s has done in cycle s+lat,
    // and the block is idle again from cycle s+lat+1.
    bit           m_active = 1'b0;
    int           m_start = 0;
    int           m_lat = 0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic [W-1:0] m_q = '0;
    logic [W-1:0] m_r = '0;
    logic         m_done = 1'b0;

    std_div_seq #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .go           (go),
        .left         (left),
        .right        (right),
        .out_quotient (out_q),
        .out_remainder(out_r),
        .done         (done)
    );

    always #5 clk = ~clk;

    function automatic int lat_of(input logic [W-1:0] b);
`ifdef STD_DIV_SEQ_ZERO_SKIP_EN
        return (b == '0) ? 1 : W + 1;
`else
        return W + 1;
`endif
    endfunction

    function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == '0) ? '1 : a / b;
    endfunction

    function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == '0) ? a : a % b;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_active = 1'b0;
            m_q      = '0;
            m_r      = '0;
            m_done   = 1'b0;
        end else begin
            if ((!m_active || cyc >= m_start + m_lat + 1) && go) begin
                m_active = 1'b1;
                m_start  = cyc;
                m_lat    = lat_of(right);
                m_a      = left;
                m_b      = right;
            end
            if (m_active && cyc == m_start + m_lat - 1) begin
                m_q = ref_q(m_a, m_b);
                m_r = ref_r(m_a, m_b);
            end
            m_done = m_active && (cyc + 1 == m_start + m_lat);
        end
        cyc++;
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_done", W'(done), W'(m_done));
            chk("model_quotient", out_q, m_q);
            chk("model_remainder", out_r, m_r);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start one operation, wait (bounded) for done, check latency/results, then
    // keep stepping to cycle `hold` and check the results are still held.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input int elat, input int hold);
        int t0;
        left  = a;
        right = b;
        go    = 1'b1;
        t0    = cyc;
        step();
        go = 1'b0;
        while (!done && cyc - t0 < 100) step();
        chk({name, "_latency"}, W'(cyc - t0), W'(elat));
        chk({name, "_q"}, out_q, eq);
        chk({name, "_r"}, out_r, er);
        step();
        while (cyc - t0 < hold) step();
        chk({name, "_hold_q"}, out_q, eq);
        chk({name, "_hold_r"}, out_r, er);
    endtask

    initial begin
        int t0;
        int rel;
        int ndone;
        int first_done;
        logic [W-1:0] x;

        step();
        step();
        chk_en = 1'b1;
        chk("reset_q", out_q, '0);
        chk("reset_r", out_r, '0);
        chk("reset_done", W'(done), '0);
        reset = 1'b0;

        run_op("div_100_7", 32'd100, 32'd7, 32'd14, 32'd2, 33, 40);
        run_op("div_5_9", 32'd5, 32'd9, 32'd0, 32'd5, 33, 0);
        run_op("div_max_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33, 0);
        run_op("div_max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 33, 0);
`ifdef STD_DIV_SEQ_ZERO_SKIP_EN
        run_op("div_by_zero", 32'd42, 32'd0, 32'hFFFF_FFFF, 32'd42, 1, 0);
`else
        run_op("div_by_zero", 32'd42, 32'd0, 32'hFFFF_FFFF, 32'd42, 33, 0);
`endif

        // go held high: back-to-back operations, operands swapped mid-run
        left  = 32'd100;
        right = 32'd7;
        go    = 1'b1;
        t0    = cyc;
        ndone = 0;
        for (int i = 1; i <= 100; i++) begin
            step();
            rel = cyc - t0;
            if (done) ndone++;
            if (rel == 5) begin
                left  = 32'd50;
                right = 32'd6;
            end
            if (rel == 33) begin
                chk("held_first_done", W'(done), 1);
                chk("held_first_q", out_q, 32'd14);
                chk("held_first_r", out_r, 32'd2);
            end
            if (rel == 67) begin
                chk("held_second_done", W'(done), 1);
                chk("held_second_q", out_q, 32'd8);
                chk("held_second_r", out_r, 32'd2);
            end
        end
        chk("held_done_count", W'(ndone), 2);
        go = 1'b0;
        repeat (40) step();

        // reset aborts an in-flight operation
        left  = 32'd100;
        right = 32'd7;
        go    = 1'b1;
        t0    = cyc;
        first_done = -1;
        for (int i = 1; i <= 60 && first_done < 0; i++) begin
            step();
            rel = cyc - t0;
            go  = 1'b0;
            if (rel == 10) reset = 1'b1;
            if (rel == 11) begin
                reset = 1'b0;
                chk("abort_q", out_q, '0);
                chk("abort_r", out_r, '0);
            end
            if (rel == 12) begin
                go    = 1'b1;
                left  = 32'd9;
                right = 32'd4;
            end
            if (done) first_done = rel;
        end
        chk("abort_first_done", W'(first_done), 45);
        chk("abort_new_q", out_q, 32'd2);
        chk("abort_new_r", out_r, 32'd1);
        step();

        // go pulsed during RUN is ignored
        left  = 32'd100;
        right = 32'd7;
        go    = 1'b1;
        t0    = cyc;
        ndone = 0;
        first_done = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            rel = cyc - t0;
            if (rel <= 20) begin
                go    = 1'b1;
                left  = 32'd9;
                right = 32'd4;
            end else begin
                go = 1'b0;
            end
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = rel;
            end
        end
        chk("ignore_done_count", W'(ndone), 1);
        chk("ignore_done_cycle", W'(first_done), 33);
        chk("ignore_q", out_q, 32'd14);
        chk("ignore_r", out_r, 32'd2);

        // randomized free-running traffic, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            go = ($urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 299) == 0);
            x = $urandom;
            case ($urandom_range(0, 3))
                0: left = x;
                1: left = x >> $urandom_range(1, 31);
                2: left = 32'hFFFF_FFFF - (x & 32'hF);
                default: left = x & 32'hFF;
            endcase
            x = $urandom;
            case ($urandom_range(0, 5))
                0: right = '0;
                1: right = (x & 32'hF) + 32'd1;
                2: right = x >> $urandom_range(1, 31);
                3: right = left;
                4: right = 32'hFFFF_FFFF;
                default: right = x;
            endcase
            step();
        end
        reset = 1'b0;
        go    = 1'b0;
        repeat (40) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
